// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-counter checker.
// Holds the checker FSM state encoding, the Err_code bit positions and the
// width of the monitored Gray count.
package gray_pkg;

  localparam int unsigned CNT_W = 3;
  localparam int unsigned ERR_W = 2;

  // Err_code bit positions
  localparam int unsigned ERR_STEP_BIT = 0;
  localparam int unsigned ERR_OVF_BIT  = 1;

  // Checker FSM states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_TRACK = 2'd1;
  localparam logic [1:0] ST_ERROR = 2'd2;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decoder.
// Ports:
//   i_gray - Gray-coded value
//   o_bin  - binary equivalent (each bit is the XOR of all Gray bits at or above it)
module gray_to_bin
  import gray_pkg::*;
(
  input  logic [CNT_W-1:0] i_gray,
  output logic [CNT_W-1:0] o_bin
);

  always_comb begin
    o_bin = '0;
    for (int unsigned i = 0; i < CNT_W; i++) begin
      o_bin[i] = ^(i_gray >> i);
    end
  end

endmodule

// File: rtl/gray_checker.sv
// Monitors an upstream 3-bit Gray counter and flags illegal steps and
// inconsistent overflow behaviour.
// Ports:
//   Clk, Reset_n - clock, asynchronous active-low reset
//   En, Cnt_rst  - enable / sync reset seen by the upstream counter this cycle
//   Gray         - upstream Gray output
//   Overflow     - upstream sticky overflow flag
//   Clear        - synchronous clear of error and wrap state
//   Binary       - registered decode of Gray (one-cycle latency)
//   Valid        - Binary and checks are meaningful
//   Wrap_cnt     - saturating count of 7->0 wraps
//   Step_err     - sticky error flag
//   Err_code     - sticky cause bits (step mismatch, overflow mismatch)
module gray_checker
  import gray_pkg::*;
#(
  parameter int unsigned WRAP_W = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              En,
  input  logic              Cnt_rst,
  input  logic [CNT_W-1:0]  Gray,
  input  logic              Overflow,
  input  logic              Clear,
  output logic [CNT_W-1:0]  Binary,
  output logic              Valid,
  output logic [WRAP_W-1:0] Wrap_cnt,
  output logic              Step_err,
  output logic [ERR_W-1:0]  Err_code
);

  logic [1:0]        r_state;
  logic              r_en_q;
  logic              r_rst_q;
  logic [CNT_W-1:0]  r_prev_b;
  logic              r_ovf_seen;
  logic [CNT_W-1:0]  r_binary;
  logic              r_valid;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_step_err;
  logic [ERR_W-1:0]  r_err_code;

  logic [CNT_W-1:0]  w_bin;
  logic [CNT_W-1:0]  w_exp_b;
  logic [CNT_W-1:0]  w_exp_gray;
  logic              w_exp_ovf;
  logic              w_wrap;
  logic [ERR_W-1:0]  w_mis;

  gray_to_bin u_g2b (
    .i_gray (Gray),
    .o_bin  (w_bin)
  );

  // The upstream output reflects En/Cnt_rst from the previous edge, so the
  // expectation is built from the registered copies.
  always_comb begin
    w_exp_b   = r_prev_b;
    w_exp_ovf = r_ovf_seen;
    w_wrap    = 1'b0;
    if (r_rst_q) begin
      w_exp_b   = '0;
      w_exp_ovf = 1'b0;
    end else if (r_en_q) begin
      w_exp_b   = r_prev_b + 1'b1;
      w_wrap    = (r_prev_b == '1) && (Gray == '0);
      w_exp_ovf = r_ovf_seen | w_wrap;
    end
    w_exp_gray            = w_exp_b ^ (w_exp_b >> 1);
    w_mis                 = '0;
    w_mis[ERR_STEP_BIT]   = (Gray != w_exp_gray);
    w_mis[ERR_OVF_BIT]    = (Overflow != w_exp_ovf);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= ST_IDLE;
      r_en_q     <= 1'b0;
      r_rst_q    <= 1'b0;
      r_prev_b   <= '0;
      r_ovf_seen <= 1'b0;
      r_binary   <= '0;
      r_valid    <= 1'b0;
      r_wrap_cnt <= '0;
      r_step_err <= 1'b0;
      r_err_code <= '0;
    end else begin
      r_en_q   <= En;
      r_rst_q  <= Cnt_rst;
      r_binary <= w_bin;
      if (Clear) begin
        r_state    <= ST_IDLE;
        r_valid    <= 1'b0;
        r_wrap_cnt <= '0;
        r_step_err <= 1'b0;
        r_err_code <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_prev_b   <= w_bin;
            r_ovf_seen <= Overflow;
            r_state    <= ST_TRACK;
            r_valid    <= 1'b1;
          end
          ST_TRACK: begin
            r_prev_b   <= w_bin;
            r_ovf_seen <= w_exp_ovf;
            if (w_wrap && (r_wrap_cnt != '1)) begin
              r_wrap_cnt <= r_wrap_cnt + 1'b1;
            end
            if (|w_mis) begin
              r_state    <= ST_ERROR;
              r_step_err <= 1'b1;
              r_err_code <= r_err_code | w_mis;
            end
          end
          ST_ERROR: begin
            // Keep following the stream so later mismatches are still judged
            // against the last observed value.
            r_prev_b   <= w_bin;
            r_ovf_seen <= w_exp_ovf;
            r_err_code <= r_err_code | w_mis;
          end
          default: begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Binary   = r_binary;
  assign Valid    = r_valid;
  assign Wrap_cnt = r_wrap_cnt;
  assign Step_err = r_step_err;
  assign Err_code = r_err_code;

endmodule

// File: tb/tb_gray_checker.sv
// Scoreboard bench for gray_checker: two instances (WRAP_W=8 and WRAP_W=2)
// share one stimulus stream produced from a model upstream Gray counter.
module tb_gray_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, cnt_rst, ovf, clr;
  logic [2:0] gray;

  logic [2:0] a_bin;  logic a_valid; logic [7:0] a_wrap; logic a_se; logic [1:0] a_code;
  logic [2:0] b_bin;  logic b_valid; logic [1:0] b_wrap; logic b_se; logic [1:0] b_code;

  always #5 clk = ~clk;

  gray_checker #(.WRAP_W(8)) u_dut8 (
    .Clk(clk), .Reset_n(rst_n), .En(en), .Cnt_rst(cnt_rst), .Gray(gray),
    .Overflow(ovf), .Clear(clr), .Binary(a_bin), .Valid(a_valid),
    .Wrap_cnt(a_wrap), .Step_err(a_se), .Err_code(a_code)
  );

  gray_checker #(.WRAP_W(2)) u_dut2 (
    .Clk(clk), .Reset_n(rst_n), .En(en), .Cnt_rst(cnt_rst), .Gray(gray),
    .Overflow(ovf), .Clear(clr), .Binary(b_bin), .Valid(b_valid),
    .Wrap_cnt(b_wrap), .Step_err(b_se), .Err_code(b_code)
  );

  typedef struct packed {
    logic [2:0] bin;
    logic       valid;
    logic [7:0] w8;
    logic [1:0] w2;
    logic       se;
    logic [1:0] code;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // upstream counter model
  int up_cnt = 0;
  bit up_ovf = 1'b0;

  // reference model of the checker's observable behaviour
  int m_mode;      // 0 = waiting for baseline, 1 = tracking, 2 = failed
  int m_prev;
  bit m_ovf_seen, m_en_q, m_rst_q;
  int m_bin, m_w8, m_w2, m_code;
  bit m_valid, m_se;

  function automatic int g_of(int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  function automatic int b_of(int g);
    for (int b = 0; b < 8; b++) if (g_of(b) == g) return b;
    return 0;
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_ovf_seen = 0; m_en_q = 0; m_rst_q = 0;
    m_bin = 0; m_w8 = 0; m_w2 = 0; m_code = 0; m_valid = 0; m_se = 0;
  endtask

  task automatic model_edge(input int g, input bit o, input bit e, input bit r, input bit c);
    int b, exp_b, mis;
    bit exp_o, wrap;
    b = b_of(g);
    m_bin = b;
    if (c) begin
      m_mode = 0; m_valid = 0; m_w8 = 0; m_w2 = 0; m_se = 0; m_code = 0;
    end else if (m_mode == 0) begin
      m_prev = b; m_ovf_seen = o; m_mode = 1; m_valid = 1;
    end else begin
      if (m_rst_q) begin
        exp_b = 0; exp_o = 0; wrap = 0;
      end else begin
        exp_b = m_en_q ? (m_prev + 1) % 8 : m_prev;
        wrap  = m_en_q && (m_prev == 7) && (g == 0);
        exp_o = m_ovf_seen || wrap;
      end
      mis = ((g != g_of(exp_b)) ? 1 : 0) + ((o != exp_o) ? 2 : 0);
      if (m_mode == 1) begin
        if (wrap) begin
          if (m_w8 < 255) m_w8++;
          if (m_w2 < 3) m_w2++;
        end
        if (mis != 0) begin
          m_mode = 2; m_se = 1;
        end
      end
      m_code = m_code | mis;
      m_prev = b; m_ovf_seen = exp_o;
    end
    m_en_q = e; m_rst_q = r;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_a"}, {a_bin, a_valid, a_wrap, a_se, a_code}, 0);
    chk({name, "_b"}, {b_bin, b_valid, b_wrap, b_se, b_code}, 0);
  endtask

  // One clock cycle of stimulus; gxor/oflip corrupt the upstream outputs.
  task automatic drive(input bit e, input bit r, input bit c,
                       input int gxor, input bit oflip, input bit rpulse);
    exp_t x;
    @(negedge clk);
    rst_n = 1'b1;
    if (rpulse) begin
      #2 rst_n = 1'b0;
      #1 check_zero("async_rst");
      model_reset();
      #1 rst_n = 1'b1;
    end
    gray    = 3'(g_of(up_cnt) ^ gxor);
    ovf     = up_ovf ^ oflip;
    en      = e;
    cnt_rst = r;
    clr     = c;
    model_edge(int'(gray), ovf, e, r, c);
    x.bin = 3'(m_bin); x.valid = m_valid; x.w8 = 8'(m_w8); x.w2 = 2'(m_w2);
    x.se = m_se; x.code = 2'(m_code);
    q.push_back(x);
    if (r) begin
      up_cnt = 0; up_ovf = 0;
    end else if (e) begin
      if (up_cnt == 7) up_ovf = 1;
      up_cnt = (up_cnt + 1) % 8;
    end
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // monitor: one expected entry per clock edge while stimulus is active
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("sb_w8", {a_bin, a_valid, a_wrap, a_se, a_code},
            {x.bin, x.valid, x.w8, x.se, x.code});
        chk("sb_w2", {b_bin, b_valid, b_wrap, b_se, b_code},
            {x.bin, x.valid, x.w2, x.se, x.code});
      end
    end
  end

  initial begin
    rst_n = 1'b0; en = 0; cnt_rst = 0; ovf = 0; clr = 0; gray = '0;
    model_reset();
    #1 check_zero("por");
    #21;

    // counting run from 000 with one wrap
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("run_wrap", a_wrap, 1);
    chk("run_err", a_se, 0);
    chk("run_bin", a_bin, 1);

    // illegal step 010 -> 111
    drive(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    after_edge();
    chk("step_code", a_code, 1);
    chk("step_bin", a_bin, 5);
    chk("step_se", a_se, 1);

    // wrap while Overflow held low
    drive(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, up_ovf, 0);
    after_edge();
    chk("wrap_noovf_code", a_code, 2);

    // Overflow rising before any wrap
    drive(0, 1, 1, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 1, 0);
    after_edge();
    chk("early_ovf_code", a_code, 2);

    // counter reset at count 5
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("cntrst_se", a_se, 0);
    chk("cntrst_bin", a_bin, 0);

    // Clear coinciding with a mismatch
    drive(1, 0, 1, 3, 1, 0);
    after_edge();
    chk("clr_se", a_se, 0);
    chk("clr_code", a_code, 0);
    chk("clr_valid", a_valid, 0);
    drive(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("clr_recapture", a_valid, 1);

    // many wraps: narrow counter saturates
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 50; i++) drive(1, 0, 0, 0, 0, 0);
    after_edge();
    chk("sat_w2", b_wrap, 3);
    chk("sat_w8", a_wrap, 6);
    drive(1, 0, 0, 0, 0, 1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit e, r, c, of, rp;
      int gx;
      e  = ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 19) == 0);
      c  = ($urandom_range(0, 39) == 0);
      gx = ($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 7)) : 0;
      of = ($urandom_range(0, 29) == 0);
      rp = ($urandom_range(0, 79) == 0);
      drive(e, r, c, gx, of, rp);
    end

    after_edge();
    chk("sb_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gray_checker.md
GRAY_CHECKER -- requirements
Module: gray_checker

Interface
REQ-001 The block SHALL have the parameter WRAP_W, default 8, giving the width of the wrap counter.
REQ-002 The block SHALL have these ports:
- Clk  input  1  sole clock; all state updates on posedge.
- Reset_n  input  1  asynchronous, active-low reset.
- En  input  1  the enable seen by the upstream Gray counter in the same cycle.
- Cnt_rst  input  1  the synchronous reset seen by the upstream Gray counter in the same cycle.
- Gray  input  3  the upstream counter's Gray-coded output.
- Overflow  input  1  the upstream counter's sticky overflow flag.
- Clear  input  1  synchronous clear of the error and wrap state.
- Binary  output  3  registered binary decode of Gray.
- Valid  output  1  Binary and the checks are meaningful.
- Wrap_cnt  output  WRAP_W  saturating count of 7->0 wraps.
- Step_err  output  1  sticky error flag.
- Err_code  output  2  sticky cause: bit0 = step mismatch, bit1 = overflow mismatch.

Function
REQ-003 Gray mapping SHALL be g = b ^ (b>>1): 0=000, 1=001, 2=011, 3=010, 4=110, 5=111, 6=101, 7=100.
REQ-004 The block SHALL register En and Cnt_rst every cycle as en_q and rst_q, because the upstream output changes one edge after its En or Cnt_rst is sampled.
REQ-005 The state machine SHALL have the states IDLE, TRACK and ERROR; the reset state is IDLE.
REQ-006 IDLE: on the next edge the block SHALL capture prev_b = bin(Gray) and ovf_seen = Overflow, then move to TRACK with Valid=1.
REQ-007 TRACK, rst_q=1: the expected values SHALL be Gray=000 and Overflow=0; the block SHALL re-baseline prev_b=0 and ovf_seen=0; Wrap_cnt is unchanged.
REQ-008 TRACK, rst_q=0 and en_q=1: the expected Gray SHALL be gray((prev_b+1) mod 8).
REQ-009 TRACK, rst_q=0 and en_q=0: the expected Gray SHALL be gray(prev_b), i.e. unchanged.
REQ-010 A wrap SHALL be prev_b=7, en_q=1, rst_q=0 and Gray=000; on a wrap, Wrap_cnt SHALL increment and saturate at 2^WRAP_W-1.
REQ-011 Expected Overflow SHALL be ovf_seen OR wrap (rst_q=0), and ovf_seen SHALL take this value.
REQ-012 A step mismatch SHALL set Err_code[0]; an Overflow mismatch SHALL set Err_code[1]; both in one cycle SHALL give 11; any mismatch moves the FSM to ERROR and sets Step_err.
REQ-013 prev_b SHALL always update to bin(Gray) as sampled, including on a mismatch.
REQ-014 ERROR: Binary SHALL keep tracking; Step_err, Err_code and Wrap_cnt SHALL hold; further mismatches SHALL OR into Err_code.
REQ-015 Clear=1 SHALL force IDLE and zero Wrap_cnt, Step_err, Err_code and Valid on that edge; Clear has priority over a simultaneous mismatch or wrap.
REQ-016 Binary SHALL equal bin(Gray) registered with one-cycle latency, in every state.
REQ-017 All outputs SHALL be registered; there is no combinational input-to-output path.

Reset
REQ-018 Reset_n=0 SHALL immediately set state=IDLE and Binary=0, Valid=0, Wrap_cnt=0, Step_err=0, Err_code=00, prev_b=0, ovf_seen=0, en_q=0, rst_q=0.
REQ-019 Reset_n deassertion mid-sequence SHALL behave as a fresh start: the first edge after release performs the IDLE capture with no check.

Structure
REQ-020 The shared package gray_pkg SHALL hold the state encoding (IDLE/TRACK/ERROR), the Err_code bit positions and the 3-bit count width constant.
REQ-021 A combinational sub-module gray_to_bin (3-bit Gray in, 3-bit binary out) SHALL be instantiated for the Gray decode; the expected-Gray encode SHALL be inline.

Verification
REQ-022 Reset, then En=1 for 10 cycles with a correct Gray stream from 000 -> Binary follows 0..7,0,1 one cycle late; Wrap_cnt=1; Overflow rise accepted; Step_err=0.
REQ-023 In TRACK with prev=3 (010) and en_q=1, drive Gray=111 -> next edge Step_err=1, Err_code=01, state ERROR, Binary=5.
REQ-024 Correct wrap 100->000 while Overflow stays 0 -> Err_code=10; separately, Overflow=1 before any wrap -> Err_code=10.
REQ-025 Cnt_rst=1 for one cycle at count 5, then Gray=000 and Overflow=0 -> no error, prev_b=0, Wrap_cnt unchanged.
REQ-026 Clear=1 in the same cycle as a mismatch -> Step_err=0, Err_code=00, Valid=0; the next edge recaptures the baseline.
REQ-027 With WRAP_W=2, drive 5 wraps -> Wrap_cnt saturates at 3; Reset_n pulsed low between edges -> outputs zero immediately, without waiting for a clock edge.
